// File: rtl/flt_pkg.sv
// Shared definitions for the fault interrupt controller: scheduler states,
// id width and the debounce-length calculation.
package flt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } sched_st_e;

  localparam int ID_W = 4;

  // Debounce window in clk cycles, floor(t_ns * freq / 1e9).
  function automatic int deb_cyc(input logic [63:0] freq, input logic [63:0] t_ns);
    logic [63:0] cyc;
    cyc = (t_ns * freq) / 64'd1_000_000_000;
    return int'(cyc);
  endfunction

endpackage

// File: rtl/flt_irq_ctrl_if.sv
// Host-side bundle of the fault interrupt controller: fault pins, host
// controls and the status/interrupt outputs.
interface flt_irq_ctrl_if #(
  parameter int N_CH = 8
);
  import flt_pkg::*;

  logic [N_CH-1:0] flt_in;
  logic [N_CH-1:0] flt_mask;
  logic [N_CH-1:0] flt_clr;
  logic            irq_ack;
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic [N_CH-1:0] flt_sts;
  logic [N_CH-1:0] flt_ovf;
  logic [N_CH-1:0] flt_lvl;
  logic            lockout;

  modport master (
    output flt_in, flt_mask, flt_clr, irq_ack,
    input  irq, irq_id, flt_sts, flt_ovf, flt_lvl, lockout
  );

  modport slave (
    input  flt_in, flt_mask, flt_clr, irq_ack,
    output irq, irq_id, flt_sts, flt_ovf, flt_lvl, lockout
  );

endinterface

// File: rtl/flt_deb.sv
// Two-flop synchroniser followed by a debounce filter: the level changes
// only after the synchronised input has held a new value for DEB_CYC+2 samples.
module flt_deb #(
  parameter int   DEB_CYC = 5,
  parameter logic RST_V   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_lvl
);

  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_s2_d;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;

  // A transition of the synchronised input restarts the count, so any
  // glitch shorter than the window never reaches the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= RST_V;
      r_s2   <= RST_V;
      r_s2_d <= RST_V;
      r_lvl  <= RST_V;
      r_cnt  <= {CW{1'b0}};
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
      if ((r_s2 != r_s2_d) || (r_s2 == r_lvl)) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt == CW'(DEB_CYC)) begin
        r_lvl <= r_s2;
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1'b1);
      end
    end
  end

  assign o_lvl = r_lvl;

endmodule

// File: rtl/flt_irq_ctrl.sv
// Fault interrupt controller: debounces fault pins, keeps sticky status and
// overflow flags, and reports pending channels one at a time by fixed priority.
module flt_irq_ctrl
  import flt_pkg::*;
#(
  parameter int          N_CH = 8,
  parameter logic [63:0] FREQ = 64'd100_000_000,
  parameter logic [63:0] T_NS = 64'd50
) (
  input  logic          clk,
  input  logic          rst_n,
  flt_irq_ctrl_if.slave bus
);

  localparam int DEB_CYC = deb_cyc(FREQ, T_NS);

  sched_st_e       r_state;
  sched_st_e       w_next;
  logic            r_irq;
  logic [ID_W-1:0] r_irq_id;
  logic [N_CH-1:0] r_lvl_d;
  logic [N_CH-1:0] r_sts;
  logic [N_CH-1:0] r_pend;
  logic [N_CH-1:0] r_ovf;

  logic [N_CH-1:0] w_lvl;
  logic [N_CH-1:0] w_evt;
  logic [N_CH-1:0] w_elig;
  logic [N_CH-1:0] w_ack_vec;
  logic [N_CH-1:0] w_clr_ok;
  logic [N_CH-1:0] w_sts_nx;
  logic [N_CH-1:0] w_pend_nx;
  logic [N_CH-1:0] w_ovf_nx;
  logic [ID_W-1:0] w_enc;
  logic            w_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    flt_deb #(
      .DEB_CYC (DEB_CYC),
      .RST_V   (1'b0)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_in  (bus.flt_in[g]),
      .o_lvl (w_lvl[g])
    );
  end

  assign w_evt     = w_lvl & ~r_lvl_d;
  assign w_elig    = r_pend & ~bus.flt_mask;
  assign w_any     = |w_elig;
  assign w_ack_vec = ((r_state == ST_REQ) && bus.irq_ack) ? (N_CH'(1'b1) << r_irq_id)
                                                          : {N_CH{1'b0}};
  // Clears are honoured only once the fault has gone away; a new event wins.
  assign w_clr_ok  = bus.flt_clr & ~w_lvl;
  assign w_sts_nx  = w_evt | (r_sts & ~w_clr_ok);
  assign w_pend_nx = w_evt | (r_pend & ~w_ack_vec);
  assign w_ovf_nx  = (w_evt & r_pend & ~w_ack_vec) | (r_ovf & ~w_clr_ok);

  // Lowest eligible index wins; scanning downwards lets it overwrite last.
  always_comb begin
    w_enc = {ID_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_enc = w_elig[i] ? ID_W'(i) : w_enc;
    end
  end

  // Scheduler next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_REQ;
        else       w_next = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.irq_ack) w_next = ST_GAP;
        else             w_next = ST_REQ;
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, sticky flags and registered interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= {ID_W{1'b0}};
      r_lvl_d  <= {N_CH{1'b0}};
      r_sts    <= {N_CH{1'b0}};
      r_pend   <= {N_CH{1'b0}};
      r_ovf    <= {N_CH{1'b0}};
    end else begin
      r_state <= w_next;
      r_irq   <= (w_next == ST_REQ);
      if ((r_state == ST_IDLE) && w_any) begin
        r_irq_id <= w_enc;
      end else begin
        r_irq_id <= r_irq_id;
      end
      r_lvl_d <= w_lvl;
      r_sts   <= w_sts_nx;
      r_pend  <= w_pend_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign bus.irq     = r_irq;
  assign bus.irq_id  = r_irq_id;
  assign bus.flt_sts = r_sts;
  assign bus.flt_ovf = r_ovf;
  assign bus.flt_lvl = w_lvl;
  assign bus.lockout = |r_sts;

endmodule

// File: tb/tb_flt_irq_ctrl.sv
// Directed test-plan scenarios plus randomized traffic, every cycle compared
// against a sample-window / rule-level reference model of the controller.
module tb_flt_irq_ctrl;

  localparam int N = 8;
  localparam int D = int'((64'd50 * 64'd100_000_000) / 64'd1_000_000_000);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  flt_irq_ctrl_if #(.N_CH(N)) bus ();

  flt_irq_ctrl #(
    .N_CH (N),
    .FREQ (64'd100_000_000),
    .T_NS (64'd50)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: raw sample history per channel and rule-level state.
  logic [D+3:0] m_sh [N];
  logic [N-1:0] m_lvl, m_lvld, m_sts, m_pend, m_ovf;
  logic         m_irq, m_gap;
  logic [3:0]   m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int c = 0; c < N; c++) m_sh[c] = '0;
    m_lvl = '0; m_lvld = '0; m_sts = '0; m_pend = '0; m_ovf = '0;
    m_irq = 1'b0; m_gap = 1'b0; m_id = 4'd0;
  endtask

  // One clock edge of the specification's rules, all from pre-edge values.
  task automatic m_edge();
    logic [N-1:0] evt, ackv, clr_ok, elig;
    logic [D+1:0] win;
    evt    = m_lvl & ~m_lvld;
    ackv   = '0;
    if (m_irq && bus.irq_ack) ackv[m_id] = 1'b1;
    clr_ok = bus.flt_clr & ~m_lvl;
    elig   = m_pend & ~bus.flt_mask;
    if (m_irq) begin
      if (bus.irq_ack) begin m_irq = 1'b0; m_gap = 1'b1; end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (elig != '0) begin
      m_irq = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = 4'(i);
    end
    m_ovf  = (m_ovf & ~clr_ok) | (evt & m_pend & ~ackv);
    m_sts  = (m_sts & ~clr_ok) | evt;
    m_pend = (m_pend & ~ackv) | evt;
    m_lvld = m_lvl;
    for (int c = 0; c < N; c++) begin
      m_sh[c] = {m_sh[c][D+2:0], bus.flt_in[c]};
      win = m_sh[c][D+3:2];
      if (&win) m_lvl[c] = 1'b1;
      else if (win == '0) m_lvl[c] = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("m_irq", bus.irq, m_irq);
    if (m_irq) chk("m_irq_id", bus.irq_id, m_id);
    chk("m_sts", bus.flt_sts, m_sts);
    chk("m_ovf", bus.flt_ovf, m_ovf);
    chk("m_lvl", bus.flt_lvl, m_lvl);
    chk("m_lockout", bus.lockout, |m_sts);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!bus.irq && n < 40) begin step(); n++; end
    chk(tag, bus.irq, 1'b1);
  endtask

  task automatic ack_once();
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
  endtask

  task automatic clear_all();
    bus.flt_clr = '1; step(); bus.flt_clr = '0;
  endtask

  initial begin
    bus.flt_in = '0; bus.flt_mask = '0; bus.flt_clr = '0; bus.irq_ack = 1'b0;
    m_reset();
    steps(3);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_id", bus.irq_id, 4'd0);
    chk("rst_sts", bus.flt_sts, 8'h00);
    chk("rst_lock", bus.lockout, 1'b0);
    rst_n = 1'b1;
    steps(4);

    // Single fault on channel 3, 7 raw samples long.
    bus.flt_in[3] = 1'b1;
    for (int k = 0; k <= D + 5; k++) begin
      step();
      if (k == 6) bus.flt_in[3] = 1'b0;
      if (k == D + 4) chk("single_irq_early", bus.irq, 1'b0);
    end
    chk("single_irq", bus.irq, 1'b1);
    chk("single_id", bus.irq_id, 4'd3);
    chk("single_sts", bus.flt_sts, 8'h08);
    chk("single_lock", bus.lockout, 1'b1);
    ack_once();
    chk("single_ack_low", bus.irq, 1'b0);
    step();
    chk("single_gap_low", bus.irq, 1'b0);
    steps(6);
    chk("single_stay_low", bus.irq, 1'b0);
    clear_all();
    chk("single_clr_lock", bus.lockout, 1'b0);

    // Glitch rejection: one 5-cycle pulse, then 6-cycle pulses every 8 cycles.
    bus.flt_in[0] = 1'b1; steps(5); bus.flt_in[0] = 1'b0; steps(12);
    chk("glitch5_lvl", bus.flt_lvl[0], 1'b0);
    for (int p = 0; p < 5; p++) begin
      bus.flt_in[0] = 1'b1; steps(6); bus.flt_in[0] = 1'b0; steps(2);
    end
    steps(12);
    chk("glitch6_sts", bus.flt_sts, 8'h00);
    chk("glitch6_irq", bus.irq, 1'b0);

    // Priority and hold: 5 and 2 together, then 0 during the request.
    bus.flt_in[5] = 1'b1; bus.flt_in[2] = 1'b1;
    wait_irq("prio_wait");
    chk("prio_first", bus.irq_id, 4'd2);
    bus.flt_in[0] = 1'b1; steps(12);
    chk("prio_hold_irq", bus.irq, 1'b1);
    chk("prio_hold_id", bus.irq_id, 4'd2);
    ack_once(); chk("prio_ack1", bus.irq, 1'b0);
    step();     chk("prio_gap1", bus.irq, 1'b0);
    step();     chk("prio_second_irq", bus.irq, 1'b1);
    chk("prio_second_id", bus.irq_id, 4'd0);
    ack_once(); chk("prio_ack2", bus.irq, 1'b0);
    step();     chk("prio_gap2", bus.irq, 1'b0);
    step();     chk("prio_third_irq", bus.irq, 1'b1);
    chk("prio_third_id", bus.irq_id, 4'd5);
    ack_once();
    bus.flt_in = '0; steps(12); clear_all();
    chk("prio_clr_lock", bus.lockout, 1'b0);

    // Overflow and clear on channel 1.
    bus.flt_in[1] = 1'b1;
    wait_irq("ovf_wait");
    bus.flt_in[1] = 1'b0; steps(12);
    bus.flt_in[1] = 1'b1; steps(12);
    chk("ovf_set", bus.flt_ovf[1], 1'b1);
    bus.flt_clr[1] = 1'b1; step(); bus.flt_clr[1] = 1'b0;
    chk("ovf_clr_active_sts", bus.flt_sts[1], 1'b1);
    chk("ovf_clr_active_ovf", bus.flt_ovf[1], 1'b1);
    ack_once();
    bus.flt_in[1] = 1'b0; steps(12);
    bus.flt_clr[1] = 1'b1; step(); bus.flt_clr[1] = 1'b0;
    chk("ovf_clr_sts", bus.flt_sts[1], 1'b0);
    chk("ovf_clr_ovf", bus.flt_ovf[1], 1'b0);
    chk("ovf_clr_lock", bus.lockout, 1'b0);

    // Masked channel 4 still sets status and lockout but raises no irq.
    bus.flt_mask[4] = 1'b1; bus.flt_in[4] = 1'b1; steps(15);
    chk("mask_sts", bus.flt_sts[4], 1'b1);
    chk("mask_lock", bus.lockout, 1'b1);
    chk("mask_irq", bus.irq, 1'b0);
    bus.flt_mask[4] = 1'b0;
    step();
    if (!bus.irq) step();
    chk("unmask_irq", bus.irq, 1'b1);
    chk("unmask_id", bus.irq_id, 4'd4);
    ack_once();
    bus.flt_in = '0; steps(12); clear_all();

    // Reset in the middle of a request with the fault still present.
    bus.flt_in[6] = 1'b1;
    wait_irq("rst_wait");
    chk("rst_pre_id", bus.irq_id, 4'd6);
    rst_n = 1'b0;
    #1;
    chk("rstmid_irq", bus.irq, 1'b0);
    chk("rstmid_id", bus.irq_id, 4'd0);
    chk("rstmid_sts", bus.flt_sts, 8'h00);
    chk("rstmid_ovf", bus.flt_ovf, 8'h00);
    chk("rstmid_lvl", bus.flt_lvl, 8'h00);
    chk("rstmid_lock", bus.lockout, 1'b0);
    m_reset();
    steps(2);
    rst_n = 1'b1;
    for (int k = 0; k <= D + 5; k++) begin
      step();
      if (k == D + 4) chk("rerep_early", bus.irq, 1'b0);
    end
    chk("rerep_irq", bus.irq, 1'b1);
    chk("rerep_id", bus.irq_id, 4'd6);
    ack_once();
    bus.flt_in = '0; steps(12); clear_all();

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 9) == 0) bus.flt_in[c] = ~bus.flt_in[c];
      if ($urandom_range(0, 63) == 0) bus.flt_mask = N'($urandom) & N'($urandom);
      bus.irq_ack = bus.irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      bus.flt_clr = N'($urandom) & N'($urandom) & N'($urandom);
      step();
    end
    bus.flt_clr = '0; bus.irq_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
